// File: rtl/ex_muldiv_unit.sv
// Iterative multiply/divide unit for the EX stage.
// MULT/MULTU use a radix-2 shift-add loop; DIV/DIVU use a restoring loop on
// operand magnitudes, with the signs applied in a single fix-up cycle.
// Results are held in registers and presented with one-cycle HI/LO strobes.
//
// Handshake: i_start is a single-cycle request that is only looked at in
// IDLE or DONE. o_busy acts as the "not ready" side of that handshake and
// also freezes IF/ID/EX. The request is accepted on the rising edge where
// i_start=1, i_flush=0, and the unit is in IDLE or DONE.
`timescale 1ns/1ps
module ex_muldiv_unit #(
    parameter int WIDTH = 32,
    parameter int ITER  = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    input  logic [1:0]       i_op,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_flush,
    output logic             o_busy,
    output logic [WIDTH-1:0] o_hi_result,
    output logic [WIDTH-1:0] o_lo_result,
    output logic             o_hi_write,
    output logic             o_lo_write,
    output logic             o_div_zero
);

    localparam int CW = (ITER > 1) ? $clog2(ITER) : 1;

    typedef enum logic [2:0] {IDLE, PREP, CALC, FIX, DONE} state_t;

    state_t             state, state_nxt;
    logic               accept;
    logic [1:0]         op_q;
    logic               a_neg, b_neg, dz;
    logic [WIDTH-1:0]   a_mag, b_mag, a_raw;
    logic [2*WIDTH-1:0] acc, acc_step;
    logic [CW-1:0]      cnt;
    logic [WIDTH-1:0]   hi_q, lo_q, hi_fix, lo_fix;

    // Multiply step signals
    logic [WIDTH:0]     mul_sum;
    // Divide step signals
    logic [WIDTH:0]     div_shift, div_diff;
    logic               div_nb;
    logic [WIDTH-1:0]   div_rem;
    // Fix-up signals
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quot, rem;

    wire is_div    = op_q[1];
    wire is_signed = ~i_op[0];

    assign accept = ((state == IDLE) || (state == DONE)) && i_start && !i_flush;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next state and stall request; a flush always returns the unit to IDLE
    always_comb begin
        state_nxt = state;
        o_busy    = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = PREP;
                    o_busy    = 1'b1;
                end
            end
            PREP: begin
                state_nxt = CALC;
                o_busy    = 1'b1;
            end
            CALC: begin
                if (cnt == CW'(ITER - 1)) state_nxt = FIX;
                o_busy = 1'b1;
            end
            FIX: begin
                state_nxt = DONE;
                o_busy    = 1'b1;
            end
            DONE: begin
                state_nxt = accept ? PREP : IDLE;
                o_busy    = accept;
            end
            default: state_nxt = IDLE;
        endcase
        if (i_flush) state_nxt = IDLE;
    end

    // One radix-2 step of multiply or divide, plus the sign fix-up
    always_comb begin
        mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, a_mag} : '0);
        div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        div_diff  = div_shift - {1'b0, b_mag};
        div_nb    = (div_shift >= {1'b0, b_mag});
        div_rem   = div_nb ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
        if (is_div) acc_step = {div_rem, acc[WIDTH-2:0], div_nb};
        else        acc_step = {mul_sum, acc[WIDTH-1:1]};

        prod_fix = (a_neg ^ b_neg) ? (~acc + 1'b1) : acc;
        quot     = acc[WIDTH-1:0];
        rem      = acc[2*WIDTH-1:WIDTH];
        if (!is_div) begin
            hi_fix = prod_fix[2*WIDTH-1:WIDTH];
            lo_fix = prod_fix[WIDTH-1:0];
        end else if (dz) begin
            hi_fix = a_raw;
            lo_fix = '1;
        end else begin
            hi_fix = a_neg ? (~rem + 1'b1) : rem;
            lo_fix = (a_neg ^ b_neg) ? (~quot + 1'b1) : quot;
        end
    end

    // Operand capture, iteration datapath and result registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q  <= '0;
            a_neg <= 1'b0;
            b_neg <= 1'b0;
            a_mag <= '0;
            b_mag <= '0;
            a_raw <= '0;
            dz    <= 1'b0;
            acc   <= '0;
            cnt   <= '0;
            hi_q  <= '0;
            lo_q  <= '0;
        end else begin
            if (accept) begin
                op_q  <= i_op;
                a_neg <= is_signed & i_a[WIDTH-1];
                b_neg <= is_signed & i_b[WIDTH-1];
                a_mag <= (is_signed & i_a[WIDTH-1]) ? (~i_a + 1'b1) : i_a;
                b_mag <= (is_signed & i_b[WIDTH-1]) ? (~i_b + 1'b1) : i_b;
                a_raw <= i_a;
            end
            case (state)
                PREP: begin
                    // Low half carries the multiplier or the dividend
                    acc <= {{WIDTH{1'b0}}, (is_div ? a_mag : b_mag)};
                    cnt <= '0;
                    dz  <= is_div && (b_mag == '0);
                end
                CALC: begin
                    acc <= acc_step;
                    cnt <= cnt + 1'b1;
                end
                FIX: begin
                    if (!i_flush) begin
                        hi_q <= hi_fix;
                        lo_q <= lo_fix;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_hi_result = hi_q;
    assign o_lo_result = lo_q;
    assign o_hi_write  = (state == DONE);
    assign o_lo_write  = (state == DONE);
    assign o_div_zero  = (state == DONE) && dz;

endmodule
